ncf_svf: RTL and testbench

- Envelope-controlled state-variable filter. It is the stage directly downstream of the NCF envelope generator.
- The 18-bit envelope output drives the cutoff coefficient. The filter processes one audio sample per DAC enable strobe and produces LP/BP/HP/notch responses.
- One shared signed multiplier is time-multiplexed by a small FSM, so one sample is computed over four clock cycles.

---
 rtl/ncf_svf_if.sv | 33 +++
 rtl/ncf_svf.sv | 186 ++++++++++++++++++
 tb/tb_ncf_svf.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ncf_svf_if.sv
// Sample/control bus of the envelope-controlled state-variable filter.
// master: drives the sample strobe, input sample, coefficients and mode.
// slave : the filter; returns the filtered sample and the valid/busy/overrun flags.
//   ena     sample strobe, one clk wide
//   din     signed input sample
//   cutoff  unsigned cutoff coefficient, Q0.18
//   damp    unsigned damping (1/Q), Q1.17
//   mode    00 LP, 01 BP, 10 HP, 11 notch
//   dout    signed filtered sample
//   valid   one-cycle pulse when dout updates
//   busy    high while a sample is being computed
//   overrun sticky, strobe seen while busy
interface ncf_svf_if;
    logic               ena;
    logic signed [17:0] din;
    logic        [17:0] cutoff;
    logic        [17:0] damp;
    logic        [1:0]  mode;
    logic signed [17:0] dout;
    logic               valid;
    logic               busy;
    logic               overrun;

    modport master (
        output ena, din, cutoff, damp, mode,
        input  dout, valid, busy, overrun
    );

    modport slave (
        input  ena, din, cutoff, damp, mode,
        output dout, valid, busy, overrun
    );
endinterface

// File: rtl/ncf_svf.sv
// Envelope-controlled state-variable filter (LP/BP/HP/notch).
// One sample is computed over four cycles with a single shared signed
// multiplier: S_LOW updates low, S_HIGH updates high, S_BAND updates band,
// S_OUT selects and saturates the output.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ncf_svf_if slave (ena/din/cutoff/damp/mode in, dout/valid/busy/overrun out)
module ncf_svf #(
    parameter logic [17:0] F_MAX = 18'h10000,
    parameter logic [17:0] Q_MIN = 18'h02000,
    parameter int unsigned ACC_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    ncf_svf_if.slave   bus
);

    localparam int unsigned D_W    = 18;
    localparam int unsigned C_W    = 18;
    localparam int unsigned PROD_W = ACC_W + C_W + 1;
    localparam int unsigned SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        S_LOW,
        S_HIGH,
        S_BAND,
        S_OUT
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   x_q, x_d;
    logic        [C_W-1:0]     f_q, f_d;
    logic        [C_W-1:0]     q_q, q_d;
    logic signed [ACC_W-1:0]   low_q, low_d;
    logic signed [ACC_W-1:0]   band_q, band_d;
    logic signed [ACC_W-1:0]   high_q, high_d;
    logic signed [D_W-1:0]     dout_q, dout_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    logic signed [ACC_W-1:0]   mul_a_c;
    logic signed [C_W:0]       mul_b_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [PROD_W-1:0]  term_c;
    logic signed [ACC_W-1:0]   notch_c;
    logic signed [ACC_W-1:0]   sel_c;

    // Clamp a wide sum to the state-register range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX) begin
            return ACC_MAX[ACC_W-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    // Clamp a state-width value to the 18-bit output range.
    function automatic logic signed [D_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX) begin
            return OUT_MAX[D_W-1:0];
        end else if (v < OUT_MIN) begin
            return OUT_MIN[D_W-1:0];
        end
        return v[D_W-1:0];
    endfunction

    // Shared multiplier: band*f in S_LOW, band*q in S_HIGH, high_new*f in S_BAND.
    // Coefficients are zero-extended so they stay positive in the signed product.
    always_comb begin
        mul_a_c = band_q;
        mul_b_c = {1'b0, f_q};
        case (state_q)
            S_HIGH:  mul_b_c = {1'b0, q_q};
            S_BAND:  mul_a_c = high_q;
            default: ;
        endcase
        prod_c = mul_a_c * mul_b_c;
        // Damping is Q1.17, cutoff is Q0.18; arithmetic shift gives floor.
        term_c = (state_q == S_HIGH) ? (prod_c >>> 17) : (prod_c >>> 18);
    end

    // Output selection; mode is sampled here in S_OUT, not at capture.
    always_comb begin
        notch_c = sat_acc(SUM_W'(high_q) + SUM_W'(low_q));
        case (bus.mode)
            2'b00:   sel_c = low_q;
            2'b01:   sel_c = band_q;
            2'b10:   sel_c = high_q;
            default: sel_c = notch_c;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        f_d       = f_q;
        q_d       = q_q;
        low_d     = low_q;
        band_d    = band_q;
        high_d    = high_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    x_d     = ACC_W'(bus.din);
                    f_d     = (bus.cutoff > F_MAX) ? F_MAX : bus.cutoff;
                    q_d     = (bus.damp < Q_MIN) ? Q_MIN : bus.damp;
                    busy_d  = 1'b1;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                low_d   = sat_acc(SUM_W'(low_q) + SUM_W'(term_c));
                state_d = S_HIGH;
            end
            S_HIGH: begin
                high_d  = sat_acc(SUM_W'(x_q) - SUM_W'(low_q) - SUM_W'(term_c));
                state_d = S_BAND;
            end
            S_BAND: begin
                band_d  = sat_acc(SUM_W'(band_q) + SUM_W'(term_c));
                state_d = S_OUT;
            end
            S_OUT: begin
                dout_d  = sat_out(sel_c);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe in any non-IDLE state (including the S_OUT return cycle) is dropped.
        if (bus.ena && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            f_q       <= '0;
            q_q       <= '0;
            low_q     <= '0;
            band_q    <= '0;
            high_q    <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            f_q       <= f_d;
            q_q       <= q_d;
            low_q     <= low_d;
            band_q    <= band_d;
            high_q    <= high_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_ncf_svf.sv
// Self-checking bench for ncf_svf: a behavioural filter model pushes the
// expected dout of every accepted sample into a queue; a negedge monitor
// pops and compares on each valid pulse.
module tb_ncf_svf;

    logic clk;
    logic rst_n;
    ncf_svf_if bus();

    ncf_svf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint exp_q[$];
    longint m_low, m_band, m_high;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_w(input longint v, input int w);
        longint mx;
        mx = (64'sd1 <<< (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic longint model_step(input int d, input int c, input int dm, input logic [1:0] md);
        longint x, f, q, sel;
        x = d;
        f = (c > 65536) ? 65536 : c;
        q = (dm < 8192) ? 8192 : dm;
        m_low  = sat_w(m_low + ((m_band * f) >>> 18), 22);
        m_high = sat_w(x - m_low - ((m_band * q) >>> 17), 22);
        m_band = sat_w(m_band + ((m_high * f) >>> 18), 22);
        case (md)
            2'b00:   sel = m_low;
            2'b01:   sel = m_band;
            2'b10:   sel = m_high;
            default: sel = sat_w(m_high + m_low, 22);
        endcase
        return sat_w(sel, 18);
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 1, 0);
            end else begin
                check_eq("dout", longint'(bus.dout), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ena = 1'b0;
        m_low = 0; m_band = 0; m_high = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for valid up to 'budget' edges; check it lands at edge 'want'.
    task automatic wait_valid(input int budget, input int want, output int got);
        bit seen;
        seen = 1'b0;
        got = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                check_eq("latency", n, want);
                got = int'(bus.dout);
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic strobe(input int d, input int c, input int dm, input logic [1:0] md);
        @(negedge clk);
        bus.din    = 18'(d);
        bus.cutoff = 18'(c);
        bus.damp   = 18'(dm);
        bus.mode   = md;
        bus.ena    = 1'b1;
        exp_q.push_back(model_step(d, c, dm, md));
        @(posedge clk);
        #1 bus.ena = 1'b0;
    endtask

    task automatic send(input int d, input int c, input int dm, input logic [1:0] md, output int got);
        strobe(d, c, dm, md);
        wait_valid(8, 4, got);
    endtask

    int got, prev;
    int seq_a[4];
    int exp1[3] = '{0, 16384, 65536};
    int exp2[3] = '{4096, 11264, -20480};

    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b0; bus.din = '0; bus.cutoff = '0; bus.damp = '0; bus.mode = 2'b00;
        #12;
        check_eq("rst_dout", longint'(bus.dout), 0);
        check_eq("rst_valid", bus.valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_overrun", bus.overrun, 0);
        do_reset();

        // Impulse response in LP/BP/HP.
        for (int m = 0; m < 3; m++) begin
            do_reset();
            send(65536, 65536, 131072, 2'(m), got);
            check_eq("impulse_s1", got, exp1[m]);
            send(0, 65536, 131072, 2'(m), got);
            check_eq("impulse_s2", got, exp2[m]);
        end

        // Cutoff clamp: 3FFFF behaves as F_MAX.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 65536 : 0, 18'h3FFFF, 131072, 2'b01, got);
            seq_a[i] = got;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 65536 : 0, 18'h10000, 131072, 2'b01, got);
            check_eq("cutoff_clamp", got, seq_a[i]);
        end

        // Damping clamp: 0 behaves as Q_MIN.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 65536 : 0, 18'h10000, 0, 2'b10, got);
            seq_a[i] = got;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 65536 : 0, 18'h10000, 18'h02000, 2'b10, got);
            check_eq("damp_clamp", got, seq_a[i]);
        end

        // Zero cutoff freezes low/band.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(65536, 0, 131072, 2'b00, got);
            check_eq("zero_cut_lp", got, 0);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(65536, 0, 131072, 2'b10, got);
            check_eq("zero_cut_hp", got, 65536);
        end

        // Overrun: second strobe two edges later is dropped.
        do_reset();
        strobe(65536, 65536, 131072, 2'b01);
        @(posedge clk);
        #1 check_eq("busy_mid", bus.busy, 1);
        @(negedge clk);
        bus.ena = 1'b1;
        @(posedge clk);
        #1 bus.ena = 1'b0;
        wait_valid(6, 2, got);
        check_eq("overrun_set", bus.overrun, 1);
        @(posedge clk);
        #1 check_eq("busy_done", bus.busy, 0);
        repeat (5) @(posedge clk);
        #1 check_eq("overrun_sticky", bus.overrun, 1);
        send(0, 65536, 131072, 2'b01, got);
        check_eq("overrun_hold", bus.overrun, 1);

        // Reset mid-sample (state S_HIGH) aborts it.
        strobe(65536, 65536, 131072, 2'b10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        m_low = 0; m_band = 0; m_high = 0;
        #1;
        check_eq("abort_dout", longint'(bus.dout), 0);
        check_eq("abort_valid", bus.valid, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 check_eq("abort_no_valid", bus.valid, 0);
        end

        // Saturation in notch mode: no rail-to-rail wrap.
        do_reset();
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            send(131071, 18'h10000, 0, 2'b11, got);
            check_eq("sat_nowrap",
                     ((prev == 131071 && got == -131072) || (prev == -131072 && got == 131071)) ? 1 : 0, 0);
            prev = got;
        end

        repeat (4) @(posedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
